// File: rtl/mfp_timer_gen.sv
// MFP68901-style timer channel: prescaled delay, event and pulse-width counting,
// with one-shot mode, selectable trigger polarity and trigger-edge capture.
module mfp_timer_gen #(
    parameter int WIDTH       = 8,
    parameter bit TRIG_RISING = 1'b1,
    parameter int PRE_MAX     = 199
) (
    input  logic             XCLK_I,
    input  logic             RST,
    input  logic             TCE,
    input  logic             DAT_WE,
    input  logic [WIDTH-1:0] DAT_I,
    input  logic             RD_LATCH,
    output logic [WIDTH-1:0] DAT_O,
    output logic [WIDTH-1:0] CAP_O,
    input  logic             CTRL_WE,
    input  logic [5:0]       CTRL_I,
    output logic [4:0]       CTRL_O,
    input  logic             T_I,
    output logic             PULSE_MODE,
    output logic             EVENT_MODE,
    output logic             T_O,
    output logic             T_O_PULSE,
    output logic             RUNNING
);

    localparam logic       ACT     = TRIG_RISING;
    localparam logic [7:0] PRE_LIM = 8'(PRE_MAX);

    // Terminal prescaler count for each divisor selection (divisor - 1).
    function automatic logic [7:0] pre_last(input logic [2:0] sel);
        case (sel)
            3'd1:    pre_last = 8'd3;
            3'd2:    pre_last = 8'd9;
            3'd3:    pre_last = 8'd15;
            3'd4:    pre_last = 8'd49;
            3'd5:    pre_last = 8'd63;
            3'd6:    pre_last = 8'd99;
            3'd7:    pre_last = 8'd199;
            default: pre_last = 8'd0;
        endcase
    endfunction

    logic [4:0]       r_ctrl;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_dat_o;
    logic [WIDTH-1:0] r_cap;
    logic [7:0]       r_pre;
    logic [1:0]       r_sync;
    logic [3:0]       r_sh;
    logic             r_qual;
    logic             r_to;
    logic             r_pulse;
    logic             r_rd_d;

    logic [2:0] w_sel;
    logic       w_running;
    logic       w_tick;
    logic       w_edge;
    logic       w_level;
    logic       w_qual;
    logic       w_timeout;

    assign w_sel     = r_ctrl[2:0];
    assign w_running = (r_ctrl[3:0] != 4'd0);
    assign w_tick    = TCE && (w_sel != 3'd0) &&
                       ((r_pre == pre_last(w_sel)) || (r_pre >= PRE_LIM));
    assign w_edge    = TCE && (r_sh[3] != ACT) && (r_sh[2] == ACT);
    assign w_level   = (r_sh[2] == ACT);
    assign w_timeout = r_qual && (r_cnt == WIDTH'(1));

    always_comb begin
        w_qual = 1'b0;
        if (!r_ctrl[3] && (w_sel != 3'd0))
            w_qual = w_tick;
        else if (r_ctrl[3:0] == 4'b1000)
            w_qual = w_edge;
        else if (r_ctrl[3])
            w_qual = w_tick && w_level;
    end

    // Trigger synchroniser runs every cycle; the shift stage only on TCE.
    always_ff @(posedge XCLK_I) begin
        if (RST) begin
            r_sync <= {2{~ACT}};
            r_sh   <= {4{~ACT}};
        end else begin
            r_sync <= {r_sync[0], T_I};
            if (TCE)
                r_sh <= {r_sh[2:0], r_sync[1]};
        end
    end

    always_ff @(posedge XCLK_I) begin
        if (RST) begin
            r_pre  <= 8'd0;
            r_qual <= 1'b0;
        end else begin
            r_qual <= w_qual;
            if (w_sel == 3'd0)
                r_pre <= 8'd0;
            else if (TCE)
                r_pre <= w_tick ? 8'd0 : r_pre + 8'd1;
        end
    end

    // Writes while stopped preload the counter; a timeout reload prefers fresh DAT_I.
    always_ff @(posedge XCLK_I) begin
        if (RST) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            if (DAT_WE)
                r_data <= DAT_I;
            if (DAT_WE && !w_running)
                r_cnt <= DAT_I;
            else if (w_timeout)
                r_cnt <= DAT_WE ? DAT_I : r_data;
            else if (r_qual)
                r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    always_ff @(posedge XCLK_I) begin
        if (RST) begin
            r_ctrl  <= 5'd0;
            r_to    <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_timeout;
            if (CTRL_WE)
                r_ctrl <= CTRL_I[4:0];
            else if (w_timeout && r_ctrl[4])
                r_ctrl[3:0] <= 4'd0;
            if (CTRL_WE && CTRL_I[5])
                r_to <= 1'b0;
            else if (w_timeout)
                r_to <= ~r_to;
        end
    end

    always_ff @(posedge XCLK_I) begin
        if (RST) begin
            r_cap   <= '0;
            r_dat_o <= '0;
            r_rd_d  <= 1'b0;
        end else begin
            r_rd_d <= RD_LATCH;
            if (w_edge)
                r_cap <= r_cnt;
            if (RD_LATCH && !r_rd_d)
                r_dat_o <= r_cnt;
        end
    end

    assign DAT_O      = r_dat_o;
    assign CAP_O      = r_cap;
    assign CTRL_O     = r_ctrl;
    assign T_O        = r_to;
    assign T_O_PULSE  = r_pulse;
    assign RUNNING    = w_running;
    assign PULSE_MODE = r_ctrl[3] && (w_sel != 3'd0);
    assign EVENT_MODE = (r_ctrl[3:0] == 4'b1000);

endmodule

// File: doc/mfp_timer_gen.md
Name: mfp_timer_gen

Overview:
- Parametrised successor to the MFP68901-style single timer, with configurable counter width and prescaler ceiling.
- Adds a one-shot mode, selectable trigger polarity, and a free-running capture of the counter on trigger edges.
- Fully synchronous to the timer clock XCLK_I, gated by a clock-enable TCE so several instances can share one fast clock.
- Instantiated per channel inside the MFP wrapper, which performs bus-to-XCLK_I synchronisation.

Parameters:
- WIDTH, 8, counter/data register width in bits (4..16).
- TRIG_RISING, 1, 1 = rising T_I edge/high level is active; 0 = falling edge/low level.
- PRE_MAX, 199, prescaler counter saturation value (resync limit after prescale change).

Ports:
- XCLK_I  in  1  timer clock.
- RST  in  1  synchronous reset, active-high.
- TCE  in  1  timer clock enable; all counting logic advances only when high.
- DAT_WE  in  1  write strobe for data register.
- DAT_I  in  WIDTH  write data.
- RD_LATCH  in  1  rising edge snapshots counter into DAT_O.
- DAT_O  out  WIDTH  latched counter value.
- CAP_O  out  WIDTH  counter value captured at last active T_I edge.
- CTRL_WE  in  1  control write strobe.
- CTRL_I  in  6  [2:0] prescale, [3] event/pulse, [4] one-shot, [5] clear T_O (strobe, not stored).
- CTRL_O  out  5  stored control bits [4:0].
- T_I  in  1  asynchronous external trigger.
- PULSE_MODE  out  1  high when ctrl[3]=1 and ctrl[2:0]!=0.
- EVENT_MODE  out  1  high when ctrl[3:0]=4'b1000.
- T_O  out  1  toggles on each timeout.
- T_O_PULSE  out  1  one XCLK_I cycle pulse per timeout.
- RUNNING  out  1  ctrl[3:0]!=0.

Behaviour:
- Reset: control=0, data=0, counter=0, prescaler=0, DAT_O=0, CAP_O=0, T_O=0, T_O_PULSE=0; RUNNING/PULSE_MODE/EVENT_MODE=0.
- Prescale divisors by ctrl[2:0] 1..7: 4, 10, 16, 50, 64, 100, 200.
  - ctrl[2:0]=0: prescaler held at 0.
  - Prescaler counts on TCE; emits tick and clears at divisor-1 or at PRE_MAX, whichever first. This bounds the first period after a divisor change to at most PRE_MAX+1.
- T_I path:
  - Two-flop synchroniser on every XCLK_I cycle, followed by a 4-stage shift register advanced on TCE.
  - Active edge = shift[3:2] pattern inactive->active per TRIG_RISING.
  - Active level = shift[2] at active polarity.
- Count qualifier (registered; counter decrements one XCLK_I cycle after qualifying tick):
  - Delay (ctrl[3]=0, ctrl[2:0]!=0): on prescaler tick.
  - Event: on active T_I edge.
  - Pulse: on prescaler tick while T_I level active.
  - Stopped: none.
- Counter:
  - On count: if counter==1, timeout; else decrement.
  - Counter value 0 decrements to all-ones, so a data value of 0 gives a period of 2^WIDTH.
- Timeout actions:
  - counter<=data; T_O toggles; T_O_PULSE=1 for one cycle.
  - If ctrl[4]=1, control[3:0] clears to 0 on the same cycle (timer stops, counter holds reloaded data).
- DAT_WE:
  - data<=DAT_I always.
  - Counter also loaded only when stopped.
  - Same-cycle timeout reload uses DAT_I (new value wins).
- CTRL_WE:
  - Stores CTRL_I[4:0].
  - CTRL_I[5]=1 forces T_O=0, overriding a same-cycle toggle; T_O_PULSE still asserts.
  - A one-shot auto-clear in the same cycle as CTRL_WE is overridden by the written control.
  - Stopping does not reload the counter; it holds its value.
- Capture: on every active T_I edge (any mode, including stopped), CAP_O<=counter. If a decrement occurs in the same cycle, the pre-decrement value is captured.
- RD_LATCH:
  - Edge-detected on XCLK_I without TCE gating.
  - DAT_O<=counter the cycle after the rising edge.
  - Holds otherwise.
- Reset mid-count: all state to reset values next edge; a pending count is discarded.

Test Plan:
- Reset, TCE=1, DAT_I=3 written while stopped, ctrl=0x01 (div 4) -> T_O_PULSE every 12 TCE cycles; T_O toggles 0->1->0; RD_LATCH reads 3,2,1 sequence.
- Data=0 with WIDTH=8, ctrl=0x01 -> first timeout after 256*4 cycles; counter passes 0->255.
- Event mode ctrl=0x08, data=2, T_I rising every 10 cycles -> timeout after 2nd edge. CAP_O=2 after 1st edge and 1 after 2nd. TRIG_RISING=0 instance counts falling edges instead.
- Pulse mode ctrl=0x09, data=5, T_I high for 8 ticks then low -> counter stops at 5-8 mod period (reaches 2 after one timeout). No decrement while T_I low.
- One-shot ctrl=0x11, data=4 -> single T_O_PULSE after 16 cycles, then RUNNING=0, CTRL_O=0x10, counter=4. Same-cycle CTRL_WE=0x01 keeps the timer running.
- DAT_WE=7 on the exact timeout cycle while running -> counter reloads 7. CTRL_WE with bit5 on the timeout cycle -> T_O=0, T_O_PULSE=1. RST asserted mid-count -> all outputs zero next cycle.
